// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
// Groups the hazard-controller signals between the pipeline datapath and
// pipeline_ctrl.
//   datapath -> ctrl : ICACHE_BUSY, DCACHE_BUSY, BRANCH_RES, EX_MEM_READ,
//                      EX_REG_WRITE, EX_RD, ID_RS1, ID_RS2, ID_USE_RS1,
//                      ID_USE_RS2
//   ctrl -> datapath : PC_HOLD, HOLD1..HOLD4, FLUSH1, FLUSH2, STALL_CNT,
//                      TIMEOUT, STATE_DBG (FSM state, 0 = INIT, 1 = RUN)
// There is no valid/ready handshake here: the busy inputs are level busy-waits
// that are sampled every cycle, and every output is a level that the datapath
// acts on at the next CLK edge.
// master = datapath side, slave = controller side.
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic        ICACHE_BUSY;
    logic        DCACHE_BUSY;
    logic        BRANCH_RES;
    logic [2:0]  EX_MEM_READ;
    logic        EX_REG_WRITE;
    logic [4:0]  EX_RD;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic        ID_USE_RS1;
    logic        ID_USE_RS2;

    logic        PC_HOLD;
    logic        HOLD1;
    logic        HOLD2;
    logic        HOLD3;
    logic        HOLD4;
    logic        FLUSH1;
    logic        FLUSH2;
    logic [15:0] STALL_CNT;
    logic        TIMEOUT;
    logic [0:0]  STATE_DBG;

    modport master (
        output ICACHE_BUSY, DCACHE_BUSY, BRANCH_RES, EX_MEM_READ, EX_REG_WRITE,
               EX_RD, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2,
        input  PC_HOLD, HOLD1, HOLD2, HOLD3, HOLD4, FLUSH1, FLUSH2,
               STALL_CNT, TIMEOUT, STATE_DBG
    );

    modport slave (
        input  ICACHE_BUSY, DCACHE_BUSY, BRANCH_RES, EX_MEM_READ, EX_REG_WRITE,
               EX_RD, ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2,
        output PC_HOLD, HOLD1, HOLD2, HOLD3, HOLD4, FLUSH1, FLUSH2,
               STALL_CNT, TIMEOUT, STATE_DBG
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard / stall controller for a 5-stage pipeline.
//   CLK   : sole clock, all state updates on posedge
//   RESET : asynchronous, active-low
//   bus   : pipeline_ctrl_if.slave (hazard inputs, hold/flush outputs,
//           stall counter, memory-wait watchdog flag, FSM state debug)
// After reset the controller spends exactly 2 cycles in INIT, holding the PC
// and flushing IF/ID and ID/EX so the pipeline starts from bubbles. In RUN the
// hold/flush outputs follow a fixed priority: memory busy, branch, load-use,
// idle. All hold/flush outputs are combinational on state and inputs.
// ----------------------------------------------------------------------------
module pipeline_ctrl (
    input logic           CLK,
    input logic           RESET,
    pipeline_ctrl_if.slave bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state;
    logic [1:0]  init_cnt;
    logic [7:0]  wait_cnt;
    logic [15:0] stall_cnt;
    logic        timeout;

    logic        busy;
    logic        load_use;
    logic        pc_hold;

    assign busy = bus.ICACHE_BUSY | bus.DCACHE_BUSY;

    // Load in EX whose destination is read by the instruction in ID. x0 never
    // creates a dependency.
    assign load_use = (bus.EX_MEM_READ != 3'd0) && bus.EX_REG_WRITE &&
                      (bus.EX_RD != 5'd0) &&
                      (((bus.EX_RD == bus.ID_RS1) && bus.ID_USE_RS1) ||
                       ((bus.EX_RD == bus.ID_RS2) && bus.ID_USE_RS2));

    always_comb begin
        pc_hold    = 1'b0;
        bus.HOLD1  = 1'b0;
        bus.HOLD2  = 1'b0;
        bus.HOLD3  = 1'b0;
        bus.HOLD4  = 1'b0;
        bus.FLUSH1 = 1'b0;
        bus.FLUSH2 = 1'b0;
        if (state == ST_INIT) begin
            pc_hold    = 1'b1;
            bus.FLUSH1 = 1'b1;
            bus.FLUSH2 = 1'b1;
        end else if (busy) begin
            // Freeze everything; a pending branch stays held in EX and is
            // acted on in the first non-busy cycle.
            pc_hold   = 1'b1;
            bus.HOLD1 = 1'b1;
            bus.HOLD2 = 1'b1;
            bus.HOLD3 = 1'b1;
            bus.HOLD4 = 1'b1;
        end else if (bus.BRANCH_RES) begin
            bus.FLUSH1 = 1'b1;
            bus.FLUSH2 = 1'b1;
        end else if (load_use) begin
            // Keep PC and IF/ID, insert one bubble into ID/EX. The bubble
            // clears EX_MEM_READ next cycle, so each load stalls only once.
            pc_hold    = 1'b1;
            bus.HOLD1  = 1'b1;
            bus.FLUSH2 = 1'b1;
        end
    end

    assign bus.PC_HOLD   = pc_hold;
    assign bus.STALL_CNT = stall_cnt;
    assign bus.TIMEOUT   = timeout;
    assign bus.STATE_DBG = state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_INIT;
            init_cnt  <= 2'd2;
            wait_cnt  <= 8'd0;
            stall_cnt <= 16'd0;
            timeout   <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt - 2'd1;
            wait_cnt <= 8'd0;
            if (init_cnt == 2'd1) begin
                state <= ST_RUN;
            end
        end else begin
            if (pc_hold && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (busy) begin
                // The edge that finds the counter already at 255 with memory
                // still busy trips the watchdog; the counter itself stays at 255.
                if (wait_cnt == 8'hFF) begin
                    timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed and randomized stimulus for pipeline_ctrl, checked cycle by cycle
// against a behavioural model (cycles left in INIT, stall count, memory-wait
// count, watchdog flag) and a priority rule table for the hold/flush outputs.
// Inputs are driven 1 ns after posedge, combinational outputs are checked at
// negedge, registered outputs 1 ns after posedge.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;
    logic CLK;
    logic RESET;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    // reference model
    int m_init_left;
    int m_stall;
    int m_wait;
    bit m_timeout;

    // {PC_HOLD, HOLD1, HOLD2, HOLD3, HOLD4, FLUSH1, FLUSH2}
    logic [6:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] rule_ctrl();
        logic busy;
        logic lu;
        busy = bus.ICACHE_BUSY | bus.DCACHE_BUSY;
        lu = (bus.EX_MEM_READ != 0) && bus.EX_REG_WRITE && (bus.EX_RD != 0) &&
             (((bus.EX_RD == bus.ID_RS1) && bus.ID_USE_RS1) ||
              ((bus.EX_RD == bus.ID_RS2) && bus.ID_USE_RS2));
        if (m_init_left > 0) return 7'b1000011;
        if (busy)            return 7'b1111100;
        if (bus.BRANCH_RES)  return 7'b0000011;
        if (lu)              return 7'b1100001;
        return 7'b0000000;
    endfunction

    function automatic logic [6:0] obs_ctrl();
        return {bus.PC_HOLD, bus.HOLD1, bus.HOLD2, bus.HOLD3, bus.HOLD4,
                bus.FLUSH1, bus.FLUSH2};
    endfunction

    task automatic model_reset();
        m_init_left = 2;
        m_stall     = 0;
        m_wait      = 0;
        m_timeout   = 1'b0;
    endtask

    task automatic model_edge(input logic [6:0] ctrl, input logic busy);
        if (m_init_left > 0) begin
            m_init_left--;
            m_wait = 0;
        end else begin
            if (ctrl[6] && m_stall < 65535) m_stall++;
            if (busy) begin
                if (m_wait == 255) m_timeout = 1'b1;
                else m_wait++;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    // driver: one clock cycle, entered and left at posedge + 1 ns
    task automatic step(input logic ib, input logic db, input logic br,
                        input logic [2:0] mr, input logic rw, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input string tag);
        logic [6:0] e;
        bus.ICACHE_BUSY  = ib;
        bus.DCACHE_BUSY  = db;
        bus.BRANCH_RES   = br;
        bus.EX_MEM_READ  = mr;
        bus.EX_REG_WRITE = rw;
        bus.EX_RD        = rd;
        bus.ID_RS1       = rs1;
        bus.ID_RS2       = rs2;
        bus.ID_USE_RS1   = u1;
        bus.ID_USE_RS2   = u2;
        exp_q.push_back(rule_ctrl());
        @(negedge CLK);
        e = exp_q.pop_front();
        chk({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(e));
        @(posedge CLK);
        #1;
        model_edge(e, ib | db);
        chk({tag, "_stall"}, 32'(bus.STALL_CNT), 32'(m_stall));
        chk({tag, "_timeout"}, 32'(bus.TIMEOUT), 32'(m_timeout));
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, tag);
    endtask

    // reset asserted between edges; outputs must change before the next edge
    task automatic do_reset(input string tag);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        chk({tag, "_rst_ctrl"}, 32'(obs_ctrl()), 32'(7'b1000011));
        chk({tag, "_rst_stall"}, 32'(bus.STALL_CNT), 32'd0);
        chk({tag, "_rst_timeout"}, 32'(bus.TIMEOUT), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        logic ib, db, br, rw, u1, u2;
        logic [2:0] mr;
        logic [4:0] rd, rs1, rs2;

        RESET = 1'b0;
        bus.ICACHE_BUSY = 0; bus.DCACHE_BUSY = 0; bus.BRANCH_RES = 0;
        bus.EX_MEM_READ = 0; bus.EX_REG_WRITE = 0; bus.EX_RD = 0;
        bus.ID_RS1 = 0; bus.ID_RS2 = 0; bus.ID_USE_RS1 = 0; bus.ID_USE_RS2 = 0;
        model_reset();
        #3;
        chk("por_ctrl", 32'(obs_ctrl()), 32'(7'b1000011));
        chk("por_stall", 32'(bus.STALL_CNT), 32'd0);
        chk("por_timeout", 32'(bus.TIMEOUT), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // two INIT cycles, then idle
        idle("init0");
        idle("init1");
        idle("idle0");
        idle("idle1");

        // load-use on RS2, then the bubble arrives, then rd = x0 never stalls
        step(0, 0, 0, 3'd3, 1, 5'd5, 5'd0, 5'd5, 0, 1, "lu_rs2");
        idle("lu_bubble");
        step(0, 0, 0, 3'd3, 1, 5'd0, 5'd0, 5'd0, 1, 1, "lu_x0");
        step(0, 0, 0, 3'd1, 1, 5'd7, 5'd7, 5'd2, 1, 0, "lu_rs1");
        step(0, 0, 0, 3'd1, 0, 5'd7, 5'd7, 5'd2, 1, 0, "lu_nowr");

        // branch beats load-use
        step(0, 0, 1, 3'd3, 1, 5'd5, 5'd0, 5'd5, 0, 1, "br_lu");

        // reset mid-INIT restarts the 2-cycle INIT
        do_reset("rst_a");
        idle("init_a0");
        do_reset("rst_b");
        idle("init_b0");
        idle("init_b1");
        idle("idle_b");

        // three busy cycles with a pending branch, then the branch flushes
        for (int i = 0; i < 3; i++) step(0, 1, 1, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "busy_br");
        step(0, 0, 1, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "br_after_busy");
        chk("stall_after_busy", 32'(bus.STALL_CNT), 32'd3);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            ib  = ($urandom_range(0, 9) == 0);
            db  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 5) == 0);
            mr  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            rw  = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            step(ib, db, br, mr, rw, rd, rs1, rs2, u1, u2, "rand");
        end

        // watchdog: 256 busy cycles trips TIMEOUT on the 256th edge
        idle("pre_wd");
        for (int i = 0; i < 256; i++) step(1, 0, 0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "wd_busy");
        chk("wd_set", 32'(bus.TIMEOUT), 32'd1);
        idle("wd_hold0");
        idle("wd_hold1");
        chk("wd_sticky", 32'(bus.TIMEOUT), 32'd1);
        do_reset("rst_wd");
        idle("init_c0");
        idle("init_c1");

        // stall counter saturation
        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        m_stall = 65534;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "sat");
        chk("stall_sat", 32'(bus.STALL_CNT), 32'h0000FFFF);
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
